// File: rtl/svnet_pkg.sv
// Shared types and constants for the svnet RAM stage and its read streamer.
package svnet_pkg;

    localparam int SVNET_RAM_R2V_DELAY = 2;
    localparam int SVNET_RAM_DEPTH     = 16;
    localparam int SVNET_RAM_WIDTH     = 8;

    // Address width for a RAM of the given depth; a single-entry RAM still needs one bit.
    function automatic int svnet_addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    localparam int SVNET_RAM_AW = svnet_addr_width(SVNET_RAM_DEPTH);

    typedef logic [SVNET_RAM_AW-1:0] ram_addr_t;

    typedef struct packed {
        logic [SVNET_RAM_WIDTH-1:0] data;
        logic                       last;
    } stream_beat_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } streamer_state_t;

endpackage

// File: rtl/svnet_stream_fifo.sv
// Show-ahead FIFO: the head entry is always visible on pop_data while non-empty.
// A pop and a push in the same cycle are both honoured, including when full.
module svnet_stream_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1),
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = mem[rd_ptr];

    // Storage array; no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/svnet_ram_streamer.sv
// Burst read engine: issues one RAM read per cycle from a (base, length) command,
// tags the final read, and streams the returned words out through a small FIFO.
// Reads are only issued against free FIFO credits, so backpressure never loses data.
module svnet_ram_streamer
    import svnet_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter int DEPTH      = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int R2V_DELAY  = SVNET_RAM_R2V_DELAY,
    localparam int AW = svnet_addr_width(DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_base,
    input  logic [AW:0]      cmd_len,
    output logic             ram_read,
    output logic [AW-1:0]    ram_read_address,
    input  logic             ram_read_data_valid,
    input  logic [WIDTH-1:0] ram_read_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             busy
);

    streamer_state_t        state;
    logic [AW-1:0]          addr;
    logic [AW-1:0]          next_addr;
    logic [AW:0]            remaining;
    logic [CW-1:0]          credits;
    logic                   issue;
    logic                   last_read;
    logic                   pop;
    logic [R2V_DELAY-1:0]   tag_pipe;
    logic [R2V_DELAY-1:0]   read_pipe;
    logic [WIDTH:0]         fifo_out;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign issue            = (state == ISSUE) && (credits != '0);
    assign last_read        = (remaining == (AW+1)'(1));
    assign next_addr        = (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
    assign pop              = out_valid && out_ready;

    assign cmd_ready        = (state == IDLE);
    assign ram_read         = issue;
    assign ram_read_address = addr;
    assign out_valid        = !fifo_empty;
    assign out_data         = fifo_out[WIDTH-1:0];
    assign out_last         = fifo_out[WIDTH];
    assign busy             = (state != IDLE) || (credits != CW'(FIFO_DEPTH));

    // Command FSM with address counter and beat countdown; zero-length commands are swallowed in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid && (cmd_len != '0)) begin
                        addr      <= cmd_base;
                        remaining <= cmd_len;
                        state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (issue) begin
                        addr      <= next_addr;
                        remaining <= remaining - (AW+1)'(1);
                        if (last_read) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Credits track free FIFO slots including words still in flight from the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            credits <= CW'(FIFO_DEPTH);
        end else begin
            case ({issue, pop})
                2'b10:   credits <= credits - CW'(1);
                2'b01:   credits <= credits + CW'(1);
                default: credits <= credits;
            endcase
        end
    end

    // Last-beat tag and read marker travel alongside the RAM latency so they meet the returning data.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe  <= '0;
            read_pipe <= '0;
        end else begin
            for (int i = R2V_DELAY - 1; i > 0; i--) begin
                tag_pipe[i]  <= tag_pipe[i-1];
                read_pipe[i] <= read_pipe[i-1];
            end
            tag_pipe[0]  <= issue && last_read;
            read_pipe[0] <= issue;
        end
    end

    svnet_stream_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ram_read_data_valid),
        .push_data ({tag_pipe[R2V_DELAY-1], ram_read_data}),
        .pop       (out_ready),
        .pop_data  (fifo_out),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Protocol and credit invariants.
    assert property (@(posedge clk) disable iff (rst)
        ram_read_data_valid |-> read_pipe[R2V_DELAY-1]);
    assert property (@(posedge clk) disable iff (rst)
        (cmd_valid && cmd_ready) |-> (cmd_len <= (AW+1)'(DEPTH)));
    assert property (@(posedge clk) disable iff (rst)
        credits <= CW'(FIFO_DEPTH));
    assert property (@(posedge clk) disable iff (rst)
        fifo_count <= CW'(FIFO_DEPTH));
    assert property (@(posedge clk) disable iff (rst)
        (ram_read_data_valid && fifo_full) |-> out_ready);

endmodule

// File: tb/tb_svnet_ram_streamer.sv
// Bench for svnet_ram_streamer: a 2-cycle RAM model feeds the DUT, and every
// address and output beat is checked against expectations computed from the command list.
module tb_svnet_ram_streamer;
    import svnet_pkg::*;

    localparam int WIDTH      = SVNET_RAM_WIDTH;
    localparam int DEPTH      = SVNET_RAM_DEPTH;
    localparam int AW         = SVNET_RAM_AW;
    localparam int FIFO_DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [AW-1:0]    cmd_base = '0;
    logic [AW:0]      cmd_len = '0;
    logic             ram_read;
    logic [AW-1:0]    ram_read_address;
    logic             ram_read_data_valid;
    logic [WIDTH-1:0] ram_read_data;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             busy;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int read_count = 0;
    int pop_count = 0;
    bit rand_ready = 1'b0;

    stream_beat_t exp_beats[$];
    ram_addr_t    exp_addr[$];
    int           pop_cycles[$];

    logic [WIDTH-1:0] ram_mem [DEPTH];
    logic [1:0]       ram_v;
    logic [WIDTH-1:0] ram_d [2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data and its valid strobe return two cycles after the read, cleared by reset.
    always @(posedge clk) begin
        if (rst) begin
            ram_v <= '0;
        end else begin
            ram_v    <= {ram_v[0], ram_read};
            ram_d[0] <= ram_mem[ram_read_address];
            ram_d[1] <= ram_d[0];
        end
    end
    assign ram_read_data_valid = ram_v[1];
    assign ram_read_data       = ram_d[1];

    svnet_ram_streamer #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .FIFO_DEPTH (FIFO_DEPTH),
        .R2V_DELAY  (SVNET_RAM_R2V_DELAY)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_base            (cmd_base),
        .cmd_len             (cmd_len),
        .ram_read            (ram_read),
        .ram_read_address    (ram_read_address),
        .ram_read_data_valid (ram_read_data_valid),
        .ram_read_data       (ram_read_data),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_data            (out_data),
        .out_last            (out_last),
        .busy                (busy)
    );

    // One comparison: counted, and reported with tag, observed and expected on mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offer a command until accepted, recording the expected addresses and beats it should produce.
    task automatic applyStimulus(input int base, input int len);
        stream_beat_t b;
        bit done = 1'b0;
        cmd_valid = 1'b1;
        cmd_base  = AW'(base);
        cmd_len   = (AW+1)'(len);
        for (int k = 0; k < 300 && !done; k++) begin
            if (cmd_ready) begin
                for (int i = 0; i < len; i++) begin
                    exp_addr.push_back(ram_addr_t'((base + i) % DEPTH));
                    b.data = WIDTH'(((base + i) % DEPTH) + 100);
                    b.last = (i == len - 1);
                    exp_beats.push_back(b);
                end
                done = 1'b1;
            end
            tick();
        end
        cmd_valid = 1'b0;
        if (!done) checkOutput("cmd_accept_timeout", 32'(0), 32'(1));
    endtask

    // Run until the engine is idle and every expected beat has been seen, within a cycle budget.
    task automatic waitIdle();
        bit done = 1'b0;
        for (int k = 0; k < 600 && !done; k++) begin
            if (!busy && exp_beats.size() == 0) done = 1'b1;
            else tick();
        end
        if (!done) checkOutput("drain_timeout", 32'(0), 32'(1));
    endtask

    // Scoreboard: every RAM read address and every accepted output beat is matched in order.
    always @(negedge clk) begin
        if (!rst) begin
            if (ram_read) begin
                read_count++;
                if (exp_addr.size() == 0) checkOutput("read_unexpected", 32'(ram_read_address), 32'hFFFF);
                else checkOutput("read_addr", 32'(ram_read_address), 32'(exp_addr.pop_front()));
            end
            if (out_valid && out_ready) begin
                stream_beat_t e;
                pop_count++;
                pop_cycles.push_back(cyc);
                if (exp_beats.size() == 0) begin
                    checkOutput("beat_unexpected", 32'({out_last, out_data}), 32'hFFFF);
                end else begin
                    e = exp_beats.pop_front();
                    checkOutput("beat", 32'({out_last, out_data}), 32'({e.last, e.data}));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int r0, p0, span;
        for (int i = 0; i < DEPTH; i++) ram_mem[i] = WIDTH'(i + 100);

        // Reset state
        tick();
        checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        checkOutput("rst_outputs", 32'({ram_read, ram_read_address, out_valid, out_last, busy}), 32'(0));
        tick();
        rst = 1'b0;
        tick();

        // Test 1: base 3, len 5 -- latency, consecutive beats, last flag, busy fall
        $display("[TB] test 1: base=3 len=5");
        applyStimulus(3, 5);
        checkOutput("t1_first_read", 32'(ram_read), 32'(1));
        tick();
        tick();
        checkOutput("t1_rdv_t3", 32'(ram_read_data_valid), 32'(1));
        tick();
        checkOutput("t1_first_data", 32'(out_data), 32'(103));
        for (int i = 0; i < 5; i++) begin
            checkOutput("t1_valid_last_busy", 32'({out_valid, out_last, busy}), 32'({1'b1, (i == 4), 1'b1}));
            tick();
        end
        checkOutput("t1_busy_fall", 32'(busy), 32'(0));
        waitIdle();

        // Test 2: address wrap at DEPTH
        $display("[TB] test 2: base=14 len=4 wraps");
        r0 = read_count;
        applyStimulus(14, 4);
        waitIdle();
        checkOutput("t2_reads", 32'(read_count - r0), 32'(4));

        // Test 3: backpressure stalls issue after FIFO_DEPTH reads
        $display("[TB] test 3: len=8 with out_ready low");
        out_ready = 1'b0;
        r0 = read_count;
        p0 = pop_count;
        applyStimulus(0, 8);
        for (int i = 0; i < 10; i++) tick();
        checkOutput("t3_reads_stalled", 32'(read_count - r0), 32'(FIFO_DEPTH));
        checkOutput("t3_read_low", 32'(ram_read), 32'(0));
        checkOutput("t3_head_held", 32'({out_valid, out_last, out_data}), 32'({1'b1, 1'b0, 8'd100}));
        out_ready = 1'b1;
        waitIdle();
        checkOutput("t3_reads_total", 32'(read_count - r0), 32'(8));
        checkOutput("t3_beats_total", 32'(pop_count - p0), 32'(8));

        // Test 4: zero-length command
        $display("[TB] test 4: len=0");
        applyStimulus(2, 0);
        checkOutput("t4_cmd_ready", 32'(cmd_ready), 32'(1));
        for (int i = 0; i < 4; i++) begin
            checkOutput("t4_quiet", 32'({ram_read, out_valid, busy}), 32'(0));
            tick();
        end

        // Test 5: back-to-back bursts
        $display("[TB] test 5: back-to-back commands");
        p0 = pop_cycles.size();
        applyStimulus(0, 2);
        applyStimulus(8, 3);
        waitIdle();
        checkOutput("t5_beats", 32'(pop_cycles.size() - p0), 32'(5));
        span = (pop_cycles.size() - p0 == 5) ? pop_cycles[p0 + 4] - pop_cycles[p0] : 99;
        checkOutput("t5_span_le5", 32'(span <= 5), 32'(1));

        // Test 6: reset mid-burst
        $display("[TB] test 6: reset mid-burst");
        p0 = pop_count;
        applyStimulus(0, 6);
        for (int k = 0; k < 100 && (pop_count - p0) < 3; k++) tick();
        checkOutput("t6_three_out", 32'(pop_count - p0), 32'(3));
        rst = 1'b1;
        exp_beats.delete();
        exp_addr.delete();
        tick();
        rst = 1'b0;
        checkOutput("t6_after_rst", 32'({out_valid, busy, cmd_ready, ram_read}), 32'(4'b0010));
        p0 = pop_count;
        applyStimulus(5, 1);
        waitIdle();
        checkOutput("t6_one_beat", 32'(pop_count - p0), 32'(1));

        // Randomized commands with random backpressure
        $display("[TB] random phase");
        rand_ready = 1'b1;
        for (int n = 0; n < 16; n++) begin
            applyStimulus($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH));
            if ($urandom_range(0, 2) == 0) tick();
        end
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        waitIdle();
        checkOutput("end_beats_left", 32'(exp_beats.size()), 32'(0));
        checkOutput("end_addrs_left", 32'(exp_addr.size()), 32'(0));
        checkOutput("end_busy", 32'({busy, out_valid, cmd_ready}), 32'(3'b001));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
